keypad_scan: RTL and testbench

Matrix-keypad scan driver for the calculator front end: drives the four column lines of a 4x4 keypad one at a time and reads back the four row lines. It synchronizes and debounces the returned rows, then emits one single-cycle strobe per accepted key press with a 4-bit key code. It is the driving end of the keypad interface. Its key_valid strobe is clean and single-cycle, so the calculator core consumes it directly with no further edge detection.

---
 rtl/keypad_scan_if.sv | 12 +
 rtl/keypad_scan.sv | 158 +++++++++++++++
 tb/tb_keypad_scan.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad bundle: column drive and row return toward the matrix, plus decoded key outputs.
// The scanner is the master end; the consumer / keypad side uses the slave modport.
interface keypad_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row_in, output col_out, key_code, key_valid, key_held);
    modport slave  (output row_in, input col_out, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column, synchronizes rows, emits one strobe per press.
// Optional feature macro: KEYPAD_SCAN_DEBOUNCE_EN (multi-sample press/release confirmation).
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1) begin : g_param_check
        $error("keypad_scan: SCAN_DIV must be >= 4 and DEBOUNCE_CNT >= 1");
    end

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    cap_row_q, cap_row_d;
    logic [3:0]    sync_q, row_s_q;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [1:0]    low_idx;
    logic          any_low, dwell_end, cap_low;
    logic [3:0]    col_dec;

`ifdef KEYPAD_SCAN_DEBOUNCE_EN
    localparam int            CW      = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    // Saturating so a long run of samples can never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`endif

    assign dwell_end = (div_q == DW'(SCAN_DIV - 1));
    assign div_d     = dwell_end ? '0 : div_q + 1'b1;
    assign any_low   = ~&row_s_q;
    assign cap_low   = ~row_s_q[cap_row_q];

    // Lowest-index pressed row wins when several rows are low together.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_q[i]) low_idx = 2'(i);
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign col_dec[gi] = (col_idx_q != 2'(gi));
    end

    assign kp.col_out   = col_dec;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = (state_q == HELD) || (state_q == RELEASE);

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cap_row_d   = cap_row_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_SCAN_DEBOUNCE_EN
        cnt_d       = cnt_q;
`endif
        if (dwell_end) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        cap_row_d = low_idx;
`ifdef KEYPAD_SCAN_DEBOUNCE_EN
                        cnt_d     = '0;
                        state_d   = DEBOUNCE;
`else
                        key_code_d  = {low_idx, col_idx_q};
                        key_valid_d = 1'b1;
                        state_d     = HELD;
`endif
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
`ifdef KEYPAD_SCAN_DEBOUNCE_EN
                DEBOUNCE: begin
                    if (cap_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_code_d  = {cap_row_q, col_idx_q};
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!cap_low) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!cap_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
`else
                HELD: begin
                    if (!cap_low) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
`endif
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            cap_row_q   <= 2'd0;
            sync_q      <= 4'hF;
            row_s_q     <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_SCAN_DEBOUNCE_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            cap_row_q   <= cap_row_d;
            sync_q      <= kp.row_in;
            row_s_q     <= sync_q;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
`ifdef KEYPAD_SCAN_DEBOUNCE_EN
            cnt_q       <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, event-level reference model, directed and random scenarios.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DC = 2;
`ifdef KEYPAD_SCAN_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic clk;
    logic rst;
    keypad_scan_if kp();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (.clk(clk), .rst(rst), .kp(kp));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad matrix: row r is pulled low iff some pressed key (r,c) has its column driven low.
    logic [3:0] pressed [4];
    logic [3:0] rows_drv;
    always_comb begin
        rows_drv = 4'hF;
        for (int r = 0; r < 4; r++) rows_drv[r] = ~|(pressed[r] & ~kp.col_out);
    end
    assign kp.row_in = rows_drv;

    int n_checks;
    int n_fail;

    // Reference model: tracks scan position and the press/confirm/release life of one key.
    int         m_cyc, m_col, m_row, m_conf;
    bit         m_held, m_rel, m_valid;
    logic [3:0] m_code, m_colo, m_h1, m_h2;

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (!r[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [3:0] rs;
        if (rst) begin
            m_cyc = 0; m_col = 0; m_row = -1; m_conf = 0;
            m_held = 0; m_rel = 0; m_valid = 0; m_code = 4'h0;
            m_h1 = 4'hF; m_h2 = 4'hF;
        end else begin
            rs = m_h2; m_h2 = m_h1; m_h1 = kp.row_in;
            m_valid = 0;
            if (m_cyc % SD == SD - 1) begin
                if (!m_held && m_row < 0) begin
                    if (rs != 4'hF) begin
                        m_row = lowest(rs); m_conf = 0;
                        if (!DEB) begin m_held = 1; m_valid = 1; m_code = 4'(m_row * 4 + m_col); end
                    end else m_col = (m_col + 1) % 4;
                end else if (!m_held) begin
                    if (!rs[m_row]) begin
                        m_conf++;
                        if (m_conf == DC) begin m_held = 1; m_valid = 1; m_code = 4'(m_row * 4 + m_col); end
                    end else begin m_row = -1; m_col = (m_col + 1) % 4; end
                end else if (!m_rel) begin
                    if (rs[m_row]) begin
                        if (DEB) begin m_rel = 1; m_conf = 0; end
                        else begin m_held = 0; m_row = -1; m_col = (m_col + 1) % 4; end
                    end
                end else begin
                    if (rs[m_row]) begin
                        m_conf++;
                        if (m_conf == DC) begin m_held = 0; m_rel = 0; m_row = -1; m_col = (m_col + 1) % 4; end
                    end else m_conf = 0;
                end
            end
            m_cyc++;
        end
        m_colo = ~(4'b0001 << m_col);
    end

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        release_all();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== 10'b1110_0000_0_0) begin
            n_fail++;
            $display("FAIL reset got=%b exp=%b", {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, 10'b1110_0000_0_0);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [3:0] exp_col;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << (((k + 1) / SD) % 4));
            n_checks++;
            if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {exp_col, 4'h0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL idle k=%0d got=%b exp=%b", k, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {exp_col, 6'b0});
            end
        end
    endtask

    task automatic test_hold_key();
        int valids = 0;
        bit fall_seen = 0;
        pressed[2][1] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) valids++;
            n_checks++;
            if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {m_colo, m_code, m_valid, m_held}) begin
                n_fail++;
                $display("FAIL hold_model t=%0t got=%b exp=%b", $time, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {m_colo, m_code, m_valid, m_held});
            end
        end
        $display("hold key (2,1): strobes=%0d code=%h held=%b", valids, kp.key_code, kp.key_held);
        n_checks++;
        if ({valids[3:0], kp.key_code, kp.key_held, kp.col_out} !== {4'd1, 4'h9, 1'b1, 4'b1101}) begin
            n_fail++;
            $display("FAIL hold_result got strobes=%0d code=%h held=%b col=%b exp strobes=1 code=9 held=1 col=1101", valids, kp.key_code, kp.key_held, kp.col_out);
        end
        release_all();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_checks++;
            if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {m_colo, m_code, m_valid, m_held}) begin
                n_fail++;
                $display("FAIL hold_release_model t=%0t got=%b exp=%b", $time, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {m_colo, m_code, m_valid, m_held});
            end
            if (!fall_seen && kp.key_held === 1'b0) begin
                fall_seen = 1;
                n_checks++;
                if (kp.col_out !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL hold_resume_col got=%b exp=1011", kp.col_out);
                end
            end
        end
        n_checks++;
        if (!fall_seen) begin
            n_fail++;
            $display("FAIL hold_release_timeout got held=%b exp held=0", kp.key_held);
        end
    endtask

    task automatic test_glitch();
        int valids = 0;
        bit aligned = 0;
        logic [3:0] prev = kp.col_out;
        for (int k = 0; k < 40 && !aligned; k++) begin
            @(negedge clk);
            aligned = (prev !== 4'b0111) && (kp.col_out === 4'b0111);
            prev = kp.col_out;
        end
        n_checks++;
        if (!aligned) begin
            n_fail++;
            $display("FAIL glitch_align_timeout got col=%b exp col=0111", kp.col_out);
        end
        pressed[0][3] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) release_all();
            @(negedge clk);
            if (kp.key_valid === 1'b1) valids++;
            n_checks++;
            if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {m_colo, m_code, m_valid, m_held}) begin
                n_fail++;
                $display("FAIL glitch_model t=%0t got=%b exp=%b", $time, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {m_colo, m_code, m_valid, m_held});
            end
        end
        $display("glitch key (0,3): strobes=%0d col=%b", valids, kp.col_out);
        n_checks++;
        if (valids !== (DEB ? 0 : 1) || kp.col_out !== 4'b1110) begin
            n_fail++;
            $display("FAIL glitch_result got strobes=%0d col=%b exp strobes=%0d col=1110", valids, kp.col_out, DEB ? 0 : 1);
        end
    endtask

    task automatic test_multi();
        int valids = 0;
        logic [3:0] code = 4'h0;
        pressed[1][3] = 1'b1;
        pressed[3][3] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k == 60) release_all();
            @(negedge clk);
            if (kp.key_valid === 1'b1) begin valids++; code = kp.key_code; end
            n_checks++;
            if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {m_colo, m_code, m_valid, m_held}) begin
                n_fail++;
                $display("FAIL multi_model t=%0t got=%b exp=%b", $time, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {m_colo, m_code, m_valid, m_held});
            end
        end
        $display("multi keys (1,3)+(3,3): strobes=%0d code=%h", valids, code);
        n_checks++;
        if (valids != 1 || code !== 4'h7) begin
            n_fail++;
            $display("FAIL multi_result got strobes=%0d code=%h exp strobes=1 code=7", valids, code);
        end
    endtask

    task automatic test_reset_while_held();
        pressed[0][0] = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (kp.key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_held_setup got held=%b exp held=1", kp.key_held);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== 10'b1110_0000_0_0) begin
            n_fail++;
            $display("FAIL rst_async got=%b exp=%b", {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, 10'b1110_0000_0_0);
        end
        @(negedge clk);
        release_all();
        rst = 1'b0;
        $display("async reset while held: outputs cleared before clock edge");
    endtask

    task automatic test_repress();
        int valids = 0;
        logic [3:0] codes [2] = '{4'h0, 4'h0};
        for (int k = 0; k < 160; k++) begin
            pressed[3][2] = (k < 40) || (k >= 80 && k < 120);
            @(negedge clk);
            if (kp.key_valid === 1'b1) begin
                if (valids < 2) codes[valids] = kp.key_code;
                valids++;
            end
            n_checks++;
            if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {m_colo, m_code, m_valid, m_held}) begin
                n_fail++;
                $display("FAIL repress_model t=%0t got=%b exp=%b", $time, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {m_colo, m_code, m_valid, m_held});
            end
        end
        release_all();
        $display("repress key (3,2): strobes=%0d codes=%h,%h", valids, codes[0], codes[1]);
        n_checks++;
        if (valids != 2 || codes[0] !== 4'hE || codes[1] !== 4'hE) begin
            n_fail++;
            $display("FAIL repress_result got strobes=%0d codes=%h,%h exp strobes=2 codes=e,e", valids, codes[0], codes[1]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            int r = $urandom_range(0, 3);
            int c = $urandom_range(0, 3);
            int plen = $urandom_range(3, 50);
            int gap = $urandom_range(5, 40);
            int valids = 0;
            pressed[r][c] = 1'b1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            for (int k = 0; k < plen + gap; k++) begin
                if (k == plen) release_all();
                @(negedge clk);
                if (kp.key_valid === 1'b1) valids++;
                n_checks++;
                if ({kp.col_out, kp.key_code, kp.key_valid, kp.key_held} !== {m_colo, m_code, m_valid, m_held}) begin
                    n_fail++;
                    $display("FAIL random_model t=%0t got=%b exp=%b", $time, {kp.col_out, kp.key_code, kp.key_valid, kp.key_held}, {m_colo, m_code, m_valid, m_held});
                end
            end
            $display("random #%0d key (%0d,%0d) press=%0d gap=%0d strobes=%0d code=%h", t, r, c, plen, gap, valids, kp.key_code);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        release_all();
        test_reset();
        test_idle();
        test_hold_key();
        test_glitch();
        test_multi();
        test_reset_while_held();
        test_repress();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
